// File: rtl/sd_adc_pkg.sv
// rtl/sd_adc_pkg.sv - shared sizing helpers for the multi-channel sigma-delta ADC
package sd_adc_pkg;

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Box-average sum never overflows: 2^lpf_bits samples of at most 2^adc_w-1
  function automatic int avg_sum_w(input int adc_w, input int lpf_bits);
    return adc_w + lpf_bits;
  endfunction

endpackage

// File: rtl/sd_adc_channel.sv
// rtl/sd_adc_channel.sv - one sigma-delta channel: feedback flop, decimating accumulator, box averager
module sd_adc_channel
  import sd_adc_pkg::*;
#(
  parameter int ADC_WIDTH      = 8,
  parameter int ACCUM_BITS     = 10,
  parameter int LPF_DEPTH_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 cmp_i,
  input  logic                 rollover_i,
  input  logic                 avg_add_i,
  input  logic                 avg_last_i,
  output logic                 delta_o,
  output logic [ADC_WIDTH-1:0] avg_o
);

  localparam int SUM_W = avg_sum_w(ADC_WIDTH, LPF_DEPTH_BITS);

  logic                  delta_q;
  logic [ACCUM_BITS-1:0] sigma_q, sigma_d;
  logic [ADC_WIDTH-1:0]  accum_q, accum_d;
  logic [SUM_W-1:0]      sum_q, sum_d, sum_next;

  // avg_o is only meaningful in the cycle the last sample of a block is added
  assign sum_next = sum_q + SUM_W'(accum_q);
  assign avg_o    = sum_next[SUM_W-1:LPF_DEPTH_BITS];
  assign delta_o  = delta_q;

  always_comb begin
    sigma_d = sigma_q;
    accum_d = accum_q;
    sum_d   = sum_q;
    if (enable) begin
      if (rollover_i) begin
        accum_d = sigma_q[ACCUM_BITS-1 -: ADC_WIDTH];
        sigma_d = ACCUM_BITS'(delta_q);
      end else if (sigma_q != '1) begin
        sigma_d = sigma_q + ACCUM_BITS'(delta_q);
      end
      if (avg_add_i) sum_d = avg_last_i ? '0 : sum_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delta_q <= 1'b0;
      sigma_q <= '0;
      accum_q <= '0;
      sum_q   <= '0;
    end else begin
      delta_q <= cmp_i;
      sigma_q <= sigma_d;
      accum_q <= accum_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: rtl/sd_adc_multi.sv
// rtl/sd_adc_multi.sv - multi-channel sigma-delta ADC with shared timing and valid/ready result arbiter
module sd_adc_multi
  import sd_adc_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int ADC_WIDTH      = 8,
  parameter int ACCUM_BITS     = 10,
  parameter int LPF_DEPTH_BITS = 3,
  localparam int CH_W          = ch_w(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_CH-1:0]    analog_cmp,
  output logic [NUM_CH-1:0]    analog_out,
  output logic [ADC_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_CH-1:0]    overrun,
  input  logic                 clr_overrun
);

  logic [ACCUM_BITS-1:0]     counter_q;
  logic                      rollover_q;
  logic                      avg_add_q;
  logic [LPF_DEPTH_BITS-1:0] lpf_cnt_q;
  logic                      avg_last;
  logic                      done;
  logic                      xfer;
  logic [NUM_CH-1:0]         xfer_sel;
  logic [ADC_WIDTH-1:0]      avg_w [NUM_CH];

  logic [NUM_CH-1:0]    pending_q, pending_d;
  logic [ADC_WIDTH-1:0] hold_q [NUM_CH];
  logic [ADC_WIDTH-1:0] hold_d [NUM_CH];
  logic [NUM_CH-1:0]    overrun_q, overrun_d;
  logic                 out_valid_q, out_valid_d;
  logic [ADC_WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]      out_ch_q, out_ch_d;

  assign avg_last = (lpf_cnt_q == '1);
  assign done     = enable & avg_add_q & avg_last;
  assign xfer     = out_valid_q & out_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sd_adc_channel #(
      .ADC_WIDTH      (ADC_WIDTH),
      .ACCUM_BITS     (ACCUM_BITS),
      .LPF_DEPTH_BITS (LPF_DEPTH_BITS)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .cmp_i      (analog_cmp[g]),
      .rollover_i (rollover_q),
      .avg_add_i  (avg_add_q),
      .avg_last_i (avg_last),
      .delta_o    (analog_out[g]),
      .avg_o      (avg_w[g])
    );
  end

  // Strobes freeze along with the counter so a pause only shifts the timeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q  <= '0;
      rollover_q <= 1'b0;
      avg_add_q  <= 1'b0;
      lpf_cnt_q  <= '0;
    end else if (enable) begin
      counter_q  <= counter_q + ACCUM_BITS'(1);
      rollover_q <= (counter_q == '1);
      avg_add_q  <= rollover_q;
      if (avg_add_q) lpf_cnt_q <= lpf_cnt_q + LPF_DEPTH_BITS'(1);
    end
  end

  always_comb begin
    xfer_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (xfer && (out_ch_q == CH_W'(i))) xfer_sel[i] = 1'b1;
    end
  end

  always_comb begin
    pending_d   = pending_q & ~xfer_sel;
    hold_d      = hold_q;
    overrun_d   = clr_overrun ? '0 : overrun_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (done) begin
        if (pending_q[i] && !xfer_sel[i]) overrun_d[i] = 1'b1;
        pending_d[i] = 1'b1;
        hold_d[i]    = avg_w[i];
      end
    end
    // Reload only when the presented word is gone; descending scan leaves the lowest index
    if (!out_valid_q || xfer) begin
      out_valid_d = |pending_d;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (pending_d[i]) begin
          out_ch_d   = CH_W'(i);
          out_data_d = hold_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      overrun_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
    end else begin
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      hold_q      <= hold_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sd_adc_multi.sv
// tb/tb_sd_adc_multi.sv - self-checking bench for sd_adc_multi (2 ch, 4-bit, 16x decimation, 2-deep average)
module tb_sd_adc_multi;

  typedef struct {
    logic [1:0] cmp;
    logic       tog;
    logic [3:0] d0;
    logic [3:0] d1;
    int         pause;
  } vec_t;

  typedef struct {
    int         ch;
    logic [3:0] d;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [1:0] cmp_base = 2'b00;
  logic       tog_en = 1'b0;
  logic       tog_bit = 1'b0;
  logic [1:0] analog_cmp;
  logic [1:0] analog_out;
  logic [1:0] overrun;
  logic [3:0] out_data;
  logic       out_ch;
  logic       out_valid;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(negedge clk) tog_bit <= ~tog_bit;
  assign analog_cmp = {cmp_base[1], tog_en ? tog_bit : cmp_base[0]};

  sd_adc_multi #(
    .NUM_CH         (2),
    .ADC_WIDTH      (4),
    .ACCUM_BITS     (4),
    .LPF_DEPTH_BITS (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .analog_cmp  (analog_cmp),
    .analog_out  (analog_out),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe at negedge, pop scoreboard on handshake, return just after the next posedge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_xfer", 32'(out_ch), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("xfer_ch", 32'(out_ch), 32'(e.ch));
        check("xfer_data", 32'(out_data), 32'(e.d));
        check("xfer_cycle", cyc, e.t);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    out_ready = 1'b0;
    clr_overrun = 1'b0;
    tog_en = 1'b0;
    cmp_base = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic drain(input string name, input int limit);
    int budget = 0;
    while (sb.size() > 0 && budget < limit) begin
      cycle();
      budget++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic run_pattern(input vec_t v);
    int shift;
    int budget;
    shift = (v.pause >= 0) ? 20 : 0;
    cmp_base = v.cmp;
    tog_en = v.tog;
    out_ready = 1'b1;
    repeat (2) cycle();
    enable = 1'b1;
    cyc = 0;
    for (int r = 0; r < 2; r++) begin
      sb.push_back('{0, v.d0, 34 + 32 * r + shift});
      sb.push_back('{1, v.d1, 35 + 32 * r + shift});
    end
    budget = 0;
    while (sb.size() > 0 && budget < 200) begin
      if (v.pause >= 0 && cyc == v.pause) enable = 1'b0;
      if (v.pause >= 0 && cyc == v.pause + 20) enable = 1'b1;
      cycle();
      budget++;
    end
    check("pattern_timeout", sb.size(), 0);
  endtask

  task automatic start_conv(input logic [1:0] c);
    cmp_base = c;
    out_ready = 1'b0;
    repeat (2) cycle();
    enable = 1'b1;
    cyc = 0;
  endtask

  // Nothing drained: presented word must sit still while both channels overrun
  task automatic seq_overrun();
    start_conv(2'b01);
    while (cyc < 70) begin
      if (cyc < 34) begin
        check("ov_idle_valid", out_valid, 0);
      end else begin
        check("ov_hold_valid", out_valid, 1);
        check("ov_hold_ch", out_ch, 0);
        check("ov_hold_data", out_data, 4'hF);
      end
      cycle();
    end
    check("ov_flags", overrun, 2'b11);
    clr_overrun = 1'b1;
    cycle();
    clr_overrun = 1'b0;
    check("ov_clr", overrun, 2'b00);
    out_ready = 1'b1;
    sb.push_back('{0, 4'hF, 71});
    sb.push_back('{1, 4'h0, 72});
    drain("ov_drain_timeout", 10);
    out_ready = 1'b0;
  endtask

  // ch0 drops to 0 before the second block; ready only in the second completion cycle
  task automatic seq_same_cycle();
    start_conv(2'b01);
    while (cyc < 65) begin
      if (cyc == 31) cmp_base = 2'b00;
      if (cyc == 33) check("sc_pre_valid", out_valid, 0);
      if (cyc >= 34) check("sc_hold_data", out_data, 4'hF);
      cycle();
    end
    out_ready = 1'b1;
    clr_overrun = 1'b1;
    sb.push_back('{0, 4'hF, 65});
    cycle();
    out_ready = 1'b0;
    clr_overrun = 1'b0;
    check("sc_old_sent", sb.size(), 0);
    check("sc_valid", out_valid, 1);
    check("sc_ch", out_ch, 0);
    check("sc_new_data", out_data, 4'h0);
    check("sc_ov0", overrun[0], 0);
    check("sc_ov1_set_wins", overrun[1], 1);
  endtask

  task automatic seq_reset_mid(input vec_t v);
    start_conv(2'b01);
    repeat (50) cycle();
    check("rm_pre_valid", out_valid, 1);
    check("rm_pre_data", out_data, 4'hF);
    check("rm_pre_ao", analog_out, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_valid", out_valid, 0);
    check("rm_data", out_data, 4'h0);
    check("rm_ao", analog_out, 2'b00);
    check("rm_ov", overrun, 2'b00);
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    run_pattern(v);
  endtask

  initial begin
    vec_t vt[6];
    vt[0] = '{2'b01, 1'b0, 4'hF, 4'h0, -1};
    vt[1] = '{2'b10, 1'b0, 4'h0, 4'hF, -1};
    vt[2] = '{2'b11, 1'b0, 4'hF, 4'hF, -1};
    vt[3] = '{2'b00, 1'b0, 4'h0, 4'h0, -1};
    vt[4] = '{2'b00, 1'b1, 4'h8, 4'h0, -1};
    vt[5] = '{2'b01, 1'b0, 4'hF, 4'h0, 10};

    cmp_base = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 4'h0);
    check("rst_ch", out_ch, 0);
    check("rst_ov", overrun, 2'b00);
    check("rst_ao", analog_out, 2'b00);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_pattern(vt[i]);
      do_reset();
    end
    seq_overrun();
    do_reset();
    seq_same_cycle();
    do_reset();
    seq_reset_mid(vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
